// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a saturating stall counter.
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data into ex_data_1/ex_data_2.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       if_id_instr,
    input  logic [DATA_W-1:0] if_id_pc_plus4,
    input  logic              if_id_valid,
    output logic [4:0]        read_reg_1,
    output logic [4:0]        read_reg_2,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    input  logic              ctrl_reg_write,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_mem_write,
    input  logic              ctrl_mem_to_reg,
    input  logic              ctrl_alu_src,
    input  logic              ctrl_reg_dst,
    input  logic              ctrl_branch,
    input  logic [1:0]        ctrl_alu_op,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic              ex_branch,
    output logic [1:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_data_1,
    output logic [DATA_W-1:0] ex_data_2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [5:0]        ex_funct,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic              hazard;
    logic              load_bubble;
    logic [DATA_W-1:0] data_1_sel;
    logic [DATA_W-1:0] data_2_sel;

    assign read_reg_1 = if_id_instr[25:21];
    assign read_reg_2 = if_id_instr[20:16];

    // A load in EX whose destination feeds the ID instruction cannot be forwarded in time.
    assign hazard = if_id_valid & ex_valid & ex_mem_read & (ex_rt != 5'd0) &
                    ((ex_rt == read_reg_1) | (ex_rt == read_reg_2));
    assign stall       = hazard & ~flush;
    assign load_bubble = flush | hazard | ~if_id_valid;

`ifdef WB_BYPASS_EN
    always_comb begin
        data_1_sel = read_data_1;
        data_2_sel = read_data_2;
        if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == read_reg_1))
            data_1_sel = wb_write_data;
        if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == read_reg_2))
            data_2_sel = wb_write_data;
    end
`else
    assign data_1_sel = read_data_1;
    assign data_2_sel = read_data_2;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (stall) state_d = BUBBLE;
            BUBBLE:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_count <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == RUN) && (state_d == BUBBLE) && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end

    // Data and address fields always follow ID; only validity and controls are zeroed for a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_data_1     <= '0;
            ex_data_2     <= '0;
            ex_imm        <= '0;
            ex_rs         <= 5'd0;
            ex_rt         <= 5'd0;
            ex_rd         <= 5'd0;
            ex_funct      <= 6'd0;
            ex_pc_plus4   <= '0;
        end else begin
            ex_data_1   <= data_1_sel;
            ex_data_2   <= data_2_sel;
            ex_imm      <= {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};
            ex_rs       <= read_reg_1;
            ex_rt       <= read_reg_2;
            ex_rd       <= if_id_instr[15:11];
            ex_funct    <= if_id_instr[5:0];
            ex_pc_plus4 <= if_id_pc_plus4;
            if (load_bubble) begin
                ex_valid      <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_reg_dst    <= 1'b0;
                ex_branch     <= 1'b0;
                ex_alu_op     <= 2'b00;
            end else begin
                ex_valid      <= 1'b1;
                ex_reg_write  <= ctrl_reg_write;
                ex_mem_read   <= ctrl_mem_read;
                ex_mem_write  <= ctrl_mem_write;
                ex_mem_to_reg <= ctrl_mem_to_reg;
                ex_alu_src    <= ctrl_alu_src;
                ex_reg_dst    <= ctrl_reg_dst;
                ex_branch     <= ctrl_branch;
                ex_alu_op     <= ctrl_alu_op;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; stall counter narrowed to 4 bits so saturation is reachable.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, branch, alu_op[1:0]}
    localparam logic [8:0] LW_CTRL  = 9'b1_1_0_1_1_0_0_00;
    localparam logic [8:0] ADD_CTRL = 9'b1_0_0_0_0_1_0_10;
    localparam logic [31:0] LW_R8   = 32'h8D28_FFFC;
    localparam logic [31:0] LW_R0   = 32'h8D20_FFFC;
    localparam logic [31:0] ADD_998 = 32'h010A_4820;
    localparam logic [31:0] ADD_900 = 32'h000A_4820;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       if_id_instr;
    logic [DATA_W-1:0] if_id_pc_plus4;
    logic              if_id_valid;
    logic [4:0]        read_reg_1, read_reg_2;
    logic [DATA_W-1:0] read_data_1, read_data_2;
    logic              ctrl_reg_write, ctrl_mem_read, ctrl_mem_write, ctrl_mem_to_reg;
    logic              ctrl_alu_src, ctrl_reg_dst, ctrl_branch;
    logic [1:0]        ctrl_alu_op;
    logic              flush;
    logic              wb_reg_write;
    logic [4:0]        wb_write_reg;
    logic [DATA_W-1:0] wb_write_data;
    logic              stall;
    logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic              ex_alu_src, ex_reg_dst, ex_branch;
    logic [1:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_data_1, ex_data_2, ex_imm, ex_pc_plus4;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [5:0]        ex_funct;
    logic [CNT_W-1:0]  stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .ctrl_reg_write(ctrl_reg_write), .ctrl_mem_read(ctrl_mem_read),
        .ctrl_mem_write(ctrl_mem_write), .ctrl_mem_to_reg(ctrl_mem_to_reg),
        .ctrl_alu_src(ctrl_alu_src), .ctrl_reg_dst(ctrl_reg_dst),
        .ctrl_branch(ctrl_branch), .ctrl_alu_op(ctrl_alu_op),
        .flush(flush), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .stall(stall),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
        .ex_alu_op(ex_alu_op), .ex_data_1(ex_data_1), .ex_data_2(ex_data_2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .ex_pc_plus4(ex_pc_plus4), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] instr, input logic [8:0] ctrl,
                                 input logic valid, input logic flush_in);
        if_id_instr     = instr;
        if_id_valid     = valid;
        flush           = flush_in;
        ctrl_reg_write  = ctrl[8];
        ctrl_mem_read   = ctrl[7];
        ctrl_mem_write  = ctrl[6];
        ctrl_mem_to_reg = ctrl[5];
        ctrl_alu_src    = ctrl[4];
        ctrl_reg_dst    = ctrl[3];
        ctrl_branch     = ctrl[2];
        ctrl_alu_op     = ctrl[1:0];
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    initial begin
        // Reset with busy inputs to show reset wins
        reset          = 1'b1;
        if_id_pc_plus4 = 32'h40;
        read_data_1    = 32'h100;
        read_data_2    = 32'h55;
        wb_reg_write   = 1'b0;
        wb_write_reg   = 5'd0;
        wb_write_data  = 32'h0;
        applyStimulus(ADD_998, 9'h1FF, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rst_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        checkOutput("rst_ex_alu_op", {30'd0, ex_alu_op}, 32'd0);
        checkOutput("rst_ex_data_1", ex_data_1, 32'd0);
        checkOutput("rst_ex_imm", ex_imm, 32'd0);
        checkOutput("rst_ex_pc", ex_pc_plus4, 32'd0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_stall_count", {28'd0, stall_count}, 32'd0);

        // Normal load of lw $8,-4($9)
        reset = 1'b0;
        applyStimulus(LW_R8, LW_CTRL, 1'b1, 1'b0);
        checkOutput("lw_read_reg_1", {27'd0, read_reg_1}, 32'd9);
        checkOutput("lw_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("lw_ex_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("lw_ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
        checkOutput("lw_ex_rs", {27'd0, ex_rs}, 32'd9);
        checkOutput("lw_ex_rt", {27'd0, ex_rt}, 32'd8);
        checkOutput("lw_ex_rd", {27'd0, ex_rd}, 32'd31);
        checkOutput("lw_ex_imm", ex_imm, 32'hFFFF_FFFC);
        checkOutput("lw_ex_funct", {26'd0, ex_funct}, 32'h3C);
        checkOutput("lw_ex_data_1", ex_data_1, 32'h100);
        checkOutput("lw_ex_pc", ex_pc_plus4, 32'h40);

        // Load-use: add $9,$8,$10 stalls one cycle
        if_id_pc_plus4 = 32'h44;
        applyStimulus(ADD_998, ADD_CTRL, 1'b1, 1'b0);
        checkOutput("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("lu_bubble_reg_write", {31'd0, ex_reg_write}, 32'd0);
        checkOutput("lu_bubble_alu_op", {30'd0, ex_alu_op}, 32'd0);
        checkOutput("lu_bubble_rs", {27'd0, ex_rs}, 32'd8);
        checkOutput("lu_count", {28'd0, stall_count}, 32'd1);
        checkOutput("lu_stall_in_bubble", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("lu_add_alu_op", {30'd0, ex_alu_op}, 32'd2);
        checkOutput("lu_add_rd", {27'd0, ex_rd}, 32'd9);
        checkOutput("lu_add_funct", {26'd0, ex_funct}, 32'h20);
        checkOutput("lu_count_after", {28'd0, stall_count}, 32'd1);

        // Load to $0 never causes a stall
        applyStimulus(LW_R0, LW_CTRL, 1'b1, 1'b0);
        tick();
        applyStimulus(ADD_900, ADD_CTRL, 1'b1, 1'b0);
        checkOutput("r0_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("r0_ex_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("r0_count", {28'd0, stall_count}, 32'd1);

        // Hazard together with flush: bubble, no stall, count unchanged
        applyStimulus(LW_R8, LW_CTRL, 1'b1, 1'b0);
        tick();
        applyStimulus(ADD_998, ADD_CTRL, 1'b1, 1'b1);
        checkOutput("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("fl_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        checkOutput("fl_count", {28'd0, stall_count}, 32'd1);
        applyStimulus(ADD_998, ADD_CTRL, 1'b1, 1'b0);
        tick();
        checkOutput("fl_next_valid", {31'd0, ex_valid}, 32'd1);

        // Invalid ID slot loads a bubble
        applyStimulus(ADD_998, ADD_CTRL, 1'b0, 1'b0);
        tick();
        checkOutput("inv_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("inv_ex_reg_dst", {31'd0, ex_reg_dst}, 32'd0);

        // Hazard through the rt field (sw $8,0($0) after lw $8)
        applyStimulus(LW_R8, LW_CTRL, 1'b1, 1'b0);
        tick();
        applyStimulus(32'hAC08_0000, 9'b0_0_1_0_1_0_0_00, 1'b1, 1'b0);
        checkOutput("rt_stall", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("rt_count", {28'd0, stall_count}, 32'd2);
        tick();
        checkOutput("rt_sw_mem_write", {31'd0, ex_mem_write}, 32'd1);

        // Write-back bypass vs direct register-file capture
        read_data_1   = 32'h0;
        read_data_2   = 32'h22;
        wb_reg_write  = 1'b1;
        wb_write_reg  = 5'd5;
        wb_write_data = 32'hDEAD_BEEF;
        applyStimulus(32'h00A0_0000, ADD_CTRL, 1'b1, 1'b0);
        tick();
`ifdef WB_BYPASS_EN
        checkOutput("wb_data_1", ex_data_1, 32'hDEAD_BEEF);
`else
        checkOutput("wb_data_1", ex_data_1, 32'h0);
`endif
        checkOutput("wb_data_2_nomatch", ex_data_2, 32'h22);
        applyStimulus(32'h0005_0000, ADD_CTRL, 1'b1, 1'b0);
        tick();
`ifdef WB_BYPASS_EN
        checkOutput("wb_data_2", ex_data_2, 32'hDEAD_BEEF);
`else
        checkOutput("wb_data_2", ex_data_2, 32'h22);
`endif
        wb_write_reg = 5'd0;
        applyStimulus(32'h0000_0000, ADD_CTRL, 1'b1, 1'b0);
        tick();
        checkOutput("wb_reg0_data_1", ex_data_1, 32'h0);
        wb_reg_write = 1'b0;

        // Drive stall_count to saturation with repeated load-use pairs
        for (int i = 0; i < 16; i++) begin
            applyStimulus(LW_R8, LW_CTRL, 1'b1, 1'b0);
            tick();
            applyStimulus(ADD_998, ADD_CTRL, 1'b1, 1'b0);
            tick();
            tick();
        end
        checkOutput("sat_count", {28'd0, stall_count}, 32'hF);
        applyStimulus(LW_R8, LW_CTRL, 1'b1, 1'b0);
        tick();
        applyStimulus(ADD_998, ADD_CTRL, 1'b1, 1'b0);
        checkOutput("sat_stall", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("sat_count_hold", {28'd0, stall_count}, 32'hF);
        tick();

        // Reset during a stall, then the held instruction loads normally
        applyStimulus(LW_R8, LW_CTRL, 1'b1, 1'b0);
        tick();
        applyStimulus(ADD_998, ADD_CTRL, 1'b1, 1'b0);
        checkOutput("rs_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("rs_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rs_count", {28'd0, stall_count}, 32'd0);
        checkOutput("rs_ex_rs", {27'd0, ex_rs}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rs_stall_after", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("rs_add_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("rs_add_rs", {27'd0, ex_rs}, 32'd8);
        checkOutput("rs_count_after", {28'd0, stall_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
